// File: rtl/mips_mc_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, state
// encodings, mux select codes and fault codes.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags the last allowed
// waiting cycle (count == TIMEOUT-1).
module mc_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Saturates at the expiry value; the FSM leaves the wait state then anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and halts on illegal opcodes or memory timeouts.
module multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       inst_done,
    output logic       halted,
    output logic [1:0] err,
    output logic [3:0] state_o
);

    state_e     state_q, state_d;
    logic [1:0] err_q, err_d;
    logic [1:0] fault;
    logic       in_wait;
    logic       tmr_clear;
    logic       tmr_count_en;
    logic       tmr_expired;

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .count_en (tmr_count_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        fault         = ERR_NONE;
        in_wait       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        inst_done     = 1'b0;
        halted        = 1'b0;

        case (state_q)
            S_FETCH: begin
                in_wait   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_source = PCS_ALU;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (tmr_expired) begin
                    state_d = S_HALT;
                    fault   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d = S_HALT;
                        fault   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                // Opcode is re-sampled here; a change away from lw/sw is a fault.
                if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_HALT;
                    fault   = ERR_ILLEGAL;
                end
            end
            S_MEM_READ: begin
                in_wait  = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (tmr_expired) begin
                    state_d = S_HALT;
                    fault   = ERR_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                inst_done  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                in_wait   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    inst_done = 1'b1;
                    state_d   = S_FETCH;
                end else if (tmr_expired) begin
                    state_d = S_HALT;
                    fault   = ERR_TIMEOUT;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                alu_op    = ALU_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                inst_done = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
                inst_done     = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCS_JUMP;
                inst_done = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                inst_done = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted  = 1'b1;
                state_d = S_HALT;
                fault   = ERR_ILLEGAL;
            end
        endcase

        tmr_clear    = (state_d != state_q);
        tmr_count_en = in_wait && !mem_ready;

        // Only the first fault is recorded; HALT is left only through reset.
        err_d = err_q;
        if ((state_d == S_HALT) && (state_q != S_HALT) && (err_q == ERR_NONE)) begin
            err_d = fault;
        end

        state_o = state_q;

        // Reset sits in FETCH, whose outputs must not reach memory while rst is low.
        if (!rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            inst_done     = 1'b0;
            halted        = 1'b0;
            state_o       = 4'd0;
        end
    end

    assign err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model expands
// each opcode and its memory wait counts into the expected per-cycle trace.
module tb_multicycle_control;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, inst_done, halted;
  logic [1:0] alu_src_b, alu_op, pc_source, err;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Plan: expected state, mem_ready and opcode to drive, one entry per cycle.
  logic [3:0]  exp_q[$];
  bit          rdy_q[$];
  logic [5:0]  op_q[$];
  // Observation word: {state[23:20], strobes[19:13], muxes[12:3], halted, err}
  logic [23:0] obs_q[$];

  multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .inst_done(inst_done), .halted(halted),
    .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] sample();
    return {state_o, pc_write, pc_write_cond, mem_read, mem_write, ir_write,
            reg_write, inst_done, i_or_d, mem_to_reg, reg_dst, alu_src_a,
            alu_src_b, alu_op, pc_source, halted, err};
  endfunction

  // Strobes {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, inst_done}
  function automatic logic [6:0] exp_strb(input logic [3:0] st, input bit rdy);
    case (st)
      4'd0:    return rdy ? 7'b1010100 : 7'b0010000;
      4'd3:    return 7'b0010000;
      4'd4:    return 7'b0000011;
      4'd5:    return rdy ? 7'b0001001 : 7'b0001000;
      4'd7:    return 7'b0000011;
      4'd8:    return 7'b0100001;
      4'd9:    return 7'b1000001;
      4'd11:   return 7'b0000011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Muxes {i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [9:0] exp_mux(input logic [3:0] st);
    case (st)
      4'd0:    return 10'b0000_01_00_00;
      4'd1:    return 10'b0000_11_00_00;
      4'd2:    return 10'b0001_10_00_00;
      4'd3:    return 10'b1000_00_00_00;
      4'd4:    return 10'b0100_00_00_00;
      4'd5:    return 10'b1000_00_00_00;
      4'd6:    return 10'b0001_00_10_00;
      4'd7:    return 10'b0010_00_00_00;
      4'd8:    return 10'b0001_00_01_01;
      4'd9:    return 10'b0000_00_00_10;
      4'd10:   return 10'b0001_10_00_00;
      default: return 10'b0000_00_00_00;
    endcase
  endfunction

  function automatic logic [23:0] exp_word(input int i);
    return {exp_q[i], exp_strb(exp_q[i], rdy_q[i]), exp_mux(exp_q[i]), 3'b000};
  endfunction

  task automatic clear_plan();
    exp_q.delete(); rdy_q.delete(); op_q.delete(); obs_q.delete();
  endtask

  task automatic push_cyc(input logic [3:0] st, input bit rdy, input logic [5:0] op);
    exp_q.push_back(st);
    rdy_q.push_back(rdy);
    // Opcode only matters in DECODE and MEM_ADDR; elsewhere drive noise.
    op_q.push_back((st == 4'd1 || st == 4'd2) ? op : 6'($urandom));
  endtask

  // Reference model: one instruction expanded to its state walk.
  task automatic plan_instr(input logic [5:0] op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) push_cyc(4'd0, 1'b0, op);
    push_cyc(4'd0, 1'b1, op);
    push_cyc(4'd1, 1'($urandom), op);
    case (op)
      6'h23: begin
        push_cyc(4'd2, 1'($urandom), op);
        for (int i = 0; i < wm; i++) push_cyc(4'd3, 1'b0, op);
        push_cyc(4'd3, 1'b1, op);
        push_cyc(4'd4, 1'($urandom), op);
      end
      6'h2B: begin
        push_cyc(4'd2, 1'($urandom), op);
        for (int i = 0; i < wm; i++) push_cyc(4'd5, 1'b0, op);
        push_cyc(4'd5, 1'b1, op);
      end
      6'h00: begin push_cyc(4'd6, 1'($urandom), op); push_cyc(4'd7, 1'($urandom), op); end
      6'h04: push_cyc(4'd8, 1'($urandom), op);
      6'h02: push_cyc(4'd9, 1'($urandom), op);
      default: begin push_cyc(4'd10, 1'($urandom), op); push_cyc(4'd11, 1'($urandom), op); end
    endcase
  endtask

  task automatic play_plan();
    obs_q.delete();
    foreach (exp_q[i]) begin
      @(negedge clk);
      mem_ready = rdy_q[i];
      opcode    = op_q[i];
      #1;
      obs_q.push_back(sample());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (sample() !== 24'h0) $display("FAIL reset_idle: got %h want %h", sample(), 24'h0);
    else n_pass++;
    @(negedge clk);
    mem_ready = 1'b1;
    opcode = 6'h23;
    #1;
    n_checks++;
    if (sample() !== 24'h0) $display("FAIL reset_ready_high: got %h want %h", sample(), 24'h0);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_lw();
    int done_at;
    int dones;
    clear_plan();
    plan_instr(6'h23, 0, 0);
    play_plan();
    done_at = -1;
    dones = 0;
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_word(i)) $display("FAIL lw cyc %0d: got %h want %h", i, obs_q[i], exp_word(i));
      else n_pass++;
      if (obs_q[i][13]) begin dones++; done_at = i; end
    end
    n_checks++;
    if (dones !== 1 || done_at !== 4) $display("FAIL lw_latency: got %0d pulses last at %0d want 1 at 4", dones, done_at);
    else n_pass++;
  endtask

  task automatic test_sw_wait();
    int mw;
    clear_plan();
    plan_instr(6'h2B, 0, 3);
    play_plan();
    mw = 0;
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_word(i)) $display("FAIL sw_wait cyc %0d: got %h want %h", i, obs_q[i], exp_word(i));
      else n_pass++;
      if (obs_q[i][16]) mw++;
    end
    n_checks++;
    if (mw !== 4) $display("FAIL sw_mem_write_len: got %0d want 4", mw);
    else n_pass++;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state_o, err} !== 6'd0) $display("FAIL sw_back_to_fetch: got %h want %h", {state_o, err}, 6'd0);
    else n_pass++;
  endtask

  task automatic test_branch_jump();
    int done_idx[$];
    clear_plan();
    plan_instr(6'h04, 0, 0);
    plan_instr(6'h02, 0, 0);
    play_plan();
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_word(i)) $display("FAIL beq_j cyc %0d: got %h want %h", i, obs_q[i], exp_word(i));
      else n_pass++;
      if (obs_q[i][13]) done_idx.push_back(i);
    end
    n_checks++;
    if (done_idx.size() != 2 || done_idx[0] != 2 || done_idx[1] != 5)
      $display("FAIL beq_j_latency: got %0d pulses want 2 at cycles 2 and 5", done_idx.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] legal[6];
    int n_instr;
    int dones;
    legal = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
    n_instr = 30;
    clear_plan();
    for (int k = 0; k < n_instr; k++) begin
      plan_instr(legal[$urandom_range(0, 5)],
                 ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3));
    end
    play_plan();
    dones = 0;
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_word(i)) $display("FAIL random cyc %0d: got %h want %h", i, obs_q[i], exp_word(i));
      else n_pass++;
      if (obs_q[i][13]) dones++;
    end
    n_checks++;
    if (dones !== n_instr) $display("FAIL random_done_count: got %0d want %0d", dones, n_instr);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      opcode = 6'($urandom);
      #1;
      n_checks++;
      if ({state_o, mem_read, err} !== 7'b0000_1_00)
        $display("FAIL timeout_wait cyc %0d: got %b want %b", c, {state_o, mem_read, err}, 7'b0000_1_00);
      else n_pass++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (sample() !== {4'd12, 7'b0, 10'b0, 3'b110})
        $display("FAIL timeout_halt cyc %0d: got %h want %h", c, sample(), {4'd12, 7'b0, 10'b0, 3'b110});
      else n_pass++;
    end
    do_reset();
    clear_plan();
    plan_instr(6'h08, TIMEOUT - 1, 0);
    play_plan();
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_word(i)) $display("FAIL timeout_edge cyc %0d: got %h want %h", i, obs_q[i], exp_word(i));
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge clk);
    mem_ready = 1'b1;
    opcode = 6'($urandom);
    @(negedge clk);
    mem_ready = 1'($urandom);
    opcode = 6'h3F;
    #1;
    n_checks++;
    if (state_o !== 4'd1) $display("FAIL illegal_decode: got %0d want 1", state_o);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
      #1;
      n_checks++;
      if (sample() !== {4'd12, 7'b0, 10'b0, 3'b101})
        $display("FAIL illegal_halt cyc %0d: got %h want %h", c, sample(), {4'd12, 7'b0, 10'b0, 3'b101});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    mem_ready = 1'b1;
    opcode = 6'h00;
    @(negedge clk);
    opcode = 6'h00;
    @(negedge clk);
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    #1;
    n_checks++;
    if (sample() !== {4'd6, 7'b0, exp_mux(4'd6), 3'b000})
      $display("FAIL mid_r_exec: got %h want %h", sample(), {4'd6, 7'b0, exp_mux(4'd6), 3'b000});
    else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (sample() !== 24'h0) $display("FAIL mid_reset_async: got %h want %h", sample(), 24'h0);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    clear_plan();
    plan_instr(6'h00, 1, 0);
    play_plan();
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_word(i)) $display("FAIL after_reset cyc %0d: got %h want %h", i, obs_q[i], exp_word(i));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch_jump();
    test_random();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
